// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the host-link command decoder: FSM states, packet
// constants, error codes and the packet checksum helper.
package gpu_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPCODE = 3'd1,
        ST_ARG_HI = 3'd2,
        ST_ARG_LO = 3'd3,
        ST_CHECK  = 3'd4,
        ST_EXEC   = 3'd5
    } cmd_state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] OP_SET_MODE  = 8'h01;
    localparam logic [7:0] OP_SET_COLOR = 8'h02;
    localparam int         PKT_LEN      = 5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_OPCODE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] op,
                                                input logic [7:0] arg_hi,
                                                input logic [7:0] arg_lo);
        return op ^ arg_hi ^ arg_lo;
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte idle counter: counts tick cycles, clears on demand, and flags
// the cycle in which the count sits at its last allowed value.
module cmd_timeout_counter #(
    parameter int unsigned TIMEOUT_CLKS = 1200
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             expired_r;

    // Next count: clear wins over tick, otherwise hold.
    always_comb begin
        count_nxt_s = count_r;
        if (i_clear) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (i_tick) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register with the expiry flag registered alongside it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_r   <= {CNT_W{1'b0}};
            expired_r <= (LAST == {CNT_W{1'b0}});
        end else begin
            count_r   <= count_nxt_s;
            expired_r <= (count_nxt_s == LAST);
        end
    end

    assign o_expired = expired_r;

endmodule

// File: rtl/gpu_command_decoder.sv
// Frames the host-link byte stream into 5-byte command packets and issues
// mode/colour load strobes or error reports for the VGA generator.
module gpu_command_decoder
    import gpu_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 1200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_set_mode,
    output logic [7:0]  o_mode,
    output logic        o_set_color,
    output logic [11:0] o_color,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [7:0]  o_err_count
);

    cmd_state_e  state_r, state_nxt_s;
    logic [7:0]  op_r, arg_hi_r, arg_lo_r;
    logic        rx_ready_r;
    logic        set_mode_r, set_color_r, err_r;
    logic [7:0]  mode_r, err_count_r;
    logic [11:0] color_r;
    logic [1:0]  err_code_r;

    logic        accept_s, in_pkt_s, expired_s, timeout_s;
    logic        check_acc_s, chk_ok_s;
    logic        exec_mode_s, exec_color_s, err_set_s;
    logic [1:0]  err_code_nxt_s;

    // Handshake, timeout qualification and packet verdict.
    always_comb begin
        accept_s       = i_rx_valid && rx_ready_r;
        in_pkt_s       = (state_r == ST_OPCODE) || (state_r == ST_ARG_HI) ||
                         (state_r == ST_ARG_LO) || (state_r == ST_CHECK);
        timeout_s      = in_pkt_s && !accept_s && expired_s;
        check_acc_s    = (state_r == ST_CHECK) && accept_s;
        chk_ok_s       = (pkt_checksum(op_r, arg_hi_r, arg_lo_r) == i_rx_data);
        exec_mode_s    = 1'b0;
        exec_color_s   = 1'b0;
        err_set_s      = 1'b0;
        err_code_nxt_s = ERR_NONE;
        if (timeout_s) begin
            err_set_s      = 1'b1;
            err_code_nxt_s = ERR_TIMEOUT;
        end else if (check_acc_s) begin
            if (!chk_ok_s) begin
                err_set_s      = 1'b1;
                err_code_nxt_s = ERR_CHECKSUM;
            end else if (op_r == OP_SET_MODE) begin
                exec_mode_s = 1'b1;
            end else if (op_r == OP_SET_COLOR) begin
                exec_color_s = 1'b1;
            end else begin
                err_set_s      = 1'b1;
                err_code_nxt_s = ERR_OPCODE;
            end
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Packet framing state machine.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (i_rx_data == SYNC_BYTE)) state_nxt_s = ST_OPCODE;
                else                                       state_nxt_s = ST_IDLE;
            end
            ST_OPCODE: begin
                if (accept_s)       state_nxt_s = ST_ARG_HI;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_OPCODE;
            end
            ST_ARG_HI: begin
                if (accept_s)       state_nxt_s = ST_ARG_LO;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_ARG_HI;
            end
            ST_ARG_LO: begin
                if (accept_s)       state_nxt_s = ST_CHECK;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_ARG_LO;
            end
            ST_CHECK: begin
                if (accept_s)       state_nxt_s = ST_EXEC;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_CHECK;
            end
            ST_EXEC: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    cmd_timeout_counter #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (!in_pkt_s || accept_s || timeout_s),
        .i_tick    (in_pkt_s && !accept_s),
        .o_expired (expired_s)
    );

    // State register; ready drops only for the single EXEC cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= (state_nxt_s != ST_EXEC);
        end
    end

    // Latch packet fields as they arrive.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_r     <= 8'h00;
            arg_hi_r <= 8'h00;
            arg_lo_r <= 8'h00;
        end else if (accept_s) begin
            case (state_r)
                ST_OPCODE: op_r     <= i_rx_data;
                ST_ARG_HI: arg_hi_r <= i_rx_data;
                ST_ARG_LO: arg_lo_r <= i_rx_data;
                default:   op_r     <= op_r;
            endcase
        end
    end

    // Registered command results and error reporting.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            set_mode_r  <= 1'b0;
            set_color_r <= 1'b0;
            err_r       <= 1'b0;
            mode_r      <= 8'h00;
            color_r     <= 12'h000;
            err_code_r  <= ERR_NONE;
            err_count_r <= 8'h00;
        end else begin
            set_mode_r  <= exec_mode_s;
            set_color_r <= exec_color_s;
            err_r       <= err_set_s;
            if (exec_mode_s)  mode_r  <= arg_lo_r;
            if (exec_color_s) color_r <= {arg_hi_r[3:0], arg_lo_r};
            if (err_set_s) begin
                err_code_r <= err_code_nxt_s;
                if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'h01;
            end
        end
    end

    assign o_rx_ready  = rx_ready_r;
    assign o_set_mode  = set_mode_r;
    assign o_mode      = mode_r;
    assign o_set_color = set_color_r;
    assign o_color     = color_r;
    assign o_err       = err_r;
    assign o_err_code  = err_code_r;
    assign o_err_count = err_count_r;

endmodule

// File: tb/tb_gpu_command_decoder.sv
// Self-checking bench for gpu_command_decoder: directed scenarios plus a
// randomized byte stream checked against a packet-level reference model.
module tb_gpu_command_decoder;
    import gpu_cmd_pkg::*;

    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready, o_set_mode, o_set_color, o_err;
    logic [7:0]  o_mode, o_err_count;
    logic [11:0] o_color;
    logic [1:0]  o_err_code;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes collected so far, idle edges inside a packet,
    // and whether the decoder is in its post-packet busy cycle.
    int          pos;
    int          idle_edges;
    bit          in_exec;
    logic [7:0]  pkt [0:4];
    logic        exp_ready, exp_set_mode, exp_set_color, exp_err;
    logic [7:0]  exp_mode, exp_count;
    logic [11:0] exp_color;
    logic [1:0]  exp_code;

    gpu_command_decoder #(.TIMEOUT_CLKS(TO)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .o_rx_ready  (o_rx_ready),
        .o_set_mode  (o_set_mode),
        .o_mode      (o_mode),
        .o_set_color (o_set_color),
        .o_color     (o_color),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_err_count (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        pos = 0; idle_edges = 0; in_exec = 0;
        exp_ready = 1'b1; exp_set_mode = 1'b0; exp_set_color = 1'b0; exp_err = 1'b0;
        exp_mode = 8'h00; exp_color = 12'h000; exp_code = 2'd0; exp_count = 8'h00;
    endtask

    task automatic raise_err(input logic [1:0] code);
        exp_err  = 1'b1;
        exp_code = code;
        if (exp_count != 8'hFF) exp_count = exp_count + 8'h01;
    endtask

    // Drive one clock of link input and advance the reference model.
    task automatic step(input logic v, input logic [7:0] d);
        bit acc;
        acc = v && !in_exec;
        i_rx_valid = v;
        i_rx_data  = d;
        @(posedge i_clk); #1;
        exp_set_mode = 1'b0; exp_set_color = 1'b0; exp_err = 1'b0;
        if (in_exec) begin
            in_exec = 0;
        end else if (pos == 0) begin
            if (acc && d == 8'hA5) begin pkt[0] = d; pos = 1; idle_edges = 0; end
        end else if (acc) begin
            pkt[pos] = d;
            idle_edges = 0;
            if (pos == PKT_LEN - 1) begin
                if ((pkt[1] ^ pkt[2] ^ pkt[3]) != pkt[4]) raise_err(2'd1);
                else if (pkt[1] == 8'h01) begin exp_set_mode = 1'b1; exp_mode = pkt[3]; end
                else if (pkt[1] == 8'h02) begin exp_set_color = 1'b1; exp_color = {pkt[2][3:0], pkt[3]}; end
                else raise_err(2'd2);
                in_exec = 1;
                pos = 0;
            end else begin
                pos++;
            end
        end else begin
            idle_edges++;
            if (idle_edges == TO) begin raise_err(2'd3); pos = 0; idle_edges = 0; end
        end
        exp_ready = !in_exec;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] chk);
        step(1'b1, 8'hA5); step(1'b1, op); step(1'b1, hi); step(1'b1, lo); step(1'b1, chk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++; if (o_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_rx_ready); end
        n_checks++; if ({o_set_mode, o_set_color, o_err} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {o_set_mode, o_set_color, o_err}); end
        n_checks++; if ({o_mode, o_color, o_err_code, o_err_count} !== 30'h0) begin n_fail++; $display("FAIL reset_values got %h/%h/%h/%h want 0", o_mode, o_color, o_err_code, o_err_count); end
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_set_mode();
        send_pkt(8'h01, 8'h00, 8'h03, 8'h02);
        n_checks++; if (o_set_mode !== 1'b1 || o_mode !== 8'h03) begin n_fail++; $display("FAIL set_mode got %b/%h want 1/03", o_set_mode, o_mode); end
        n_checks++; if (o_rx_ready !== 1'b0 || o_err !== 1'b0) begin n_fail++; $display("FAIL exec_cycle ready/err got %b/%b want 0/0", o_rx_ready, o_err); end
        step(1'b0, 8'h00);
        n_checks++; if (o_set_mode !== 1'b0 || o_rx_ready !== 1'b1) begin n_fail++; $display("FAIL mode_after got %b/%b want 0/1", o_set_mode, o_rx_ready); end
    endtask

    task automatic test_set_color();
        send_pkt(8'h02, 8'h0F, 8'h3C, 8'h31);
        n_checks++; if (o_set_color !== 1'b1 || o_color !== 12'hF3C) begin n_fail++; $display("FAIL color_1 got %b/%h want 1/F3C", o_set_color, o_color); end
        step(1'b0, 8'h00);
        send_pkt(8'h02, 8'hF1, 8'h23, 8'hD0);
        n_checks++; if (o_set_color !== 1'b1 || o_color !== 12'h123) begin n_fail++; $display("FAIL color_2 got %b/%h want 1/123", o_set_color, o_color); end
        step(1'b0, 8'h00);
    endtask

    task automatic test_chk_error();
        send_pkt(8'h01, 8'h00, 8'h03, 8'hFF);
        n_checks++; if (o_err !== 1'b1 || o_err_code !== 2'd1 || o_err_count !== 8'd1) begin n_fail++; $display("FAIL chk_err got %b/%0d/%0d want 1/1/1", o_err, o_err_code, o_err_count); end
        n_checks++; if (o_set_mode !== 1'b0 || o_mode !== 8'h03) begin n_fail++; $display("FAIL chk_err_mode got %b/%h want 0/03", o_set_mode, o_mode); end
        step(1'b0, 8'h00);
        step(1'b1, 8'h12); step(1'b1, 8'h34);
        send_pkt(8'h01, 8'h00, 8'h05, 8'h04);
        n_checks++; if (o_set_mode !== 1'b1 || o_mode !== 8'h05 || o_err !== 1'b0) begin n_fail++; $display("FAIL junk_then_mode got %b/%h/%b want 1/05/0", o_set_mode, o_mode, o_err); end
        n_checks++; if (o_err_count !== 8'd1) begin n_fail++; $display("FAIL junk_silent count got %0d want 1", o_err_count); end
        step(1'b0, 8'h00);
    endtask

    task automatic test_bad_opcode();
        send_pkt(8'h07, 8'h00, 8'h00, 8'h07);
        n_checks++; if (o_err !== 1'b1 || o_err_code !== 2'd2 || o_err_count !== 8'd2) begin n_fail++; $display("FAIL bad_op got %b/%0d/%0d want 1/2/2", o_err, o_err_code, o_err_count); end
        n_checks++; if (o_set_mode !== 1'b0 || o_set_color !== 1'b0) begin n_fail++; $display("FAIL bad_op_strobes got %b/%b want 0/0", o_set_mode, o_set_color); end
        step(1'b0, 8'h00);
    endtask

    task automatic test_timeout();
        step(1'b1, 8'hA5); step(1'b1, 8'h01);
        repeat (TO - 1) step(1'b0, 8'($urandom));
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", o_err); end
        step(1'b0, 8'h00);
        n_checks++; if (o_err !== 1'b1 || o_err_code !== 2'd3 || o_err_count !== 8'd3) begin n_fail++; $display("FAIL timeout got %b/%0d/%0d want 1/3/3", o_err, o_err_code, o_err_count); end
        send_pkt(8'h01, 8'h00, 8'h0A, 8'h0B);
        n_checks++; if (o_set_mode !== 1'b1 || o_mode !== 8'h0A) begin n_fail++; $display("FAIL after_timeout got %b/%h want 1/0A", o_set_mode, o_mode); end
        step(1'b0, 8'h00);
        // Byte arriving on the expiry cycle keeps the packet alive.
        step(1'b1, 8'hA5); step(1'b1, 8'h01);
        repeat (TO - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL accept_wins got %b want 0", o_err); end
        repeat (TO - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h03);
        repeat (TO - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h02);
        n_checks++; if (o_set_mode !== 1'b1 || o_mode !== 8'h03 || o_err_count !== 8'd3) begin n_fail++; $display("FAIL slow_pkt got %b/%h/%0d want 1/03/3", o_set_mode, o_mode, o_err_count); end
        step(1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [8:0] q [$];
        logic [7:0] op, hi, lo, chk;
        int kind, r, g;
        for (int p = 0; p < 250; p++) begin
            kind = $urandom_range(0, 9);
            hi = 8'($urandom); lo = 8'($urandom);
            op = (kind < 4) ? 8'h01 : (kind < 7) ? 8'h02 : 8'($urandom);
            chk = op ^ hi ^ lo;
            if (kind == 7) chk = chk ^ 8'($urandom_range(1, 255));
            if (kind == 9) q.push_back({1'b1, 8'($urandom)});
            else begin
                q.push_back({1'b1, 8'hA5}); q.push_back({1'b1, op});
                q.push_back({1'b1, hi});    q.push_back({1'b1, lo}); q.push_back({1'b1, chk});
            end
            r = $urandom_range(0, 19);
            g = (r == 0) ? TO + $urandom_range(0, 2) : (r < 12) ? 0 : $urandom_range(1, TO - 2);
            for (int k = 0; k < g; k++) q.push_back({1'b0, 8'($urandom)});
        end
        foreach (q[i]) begin
            step(q[i][8], q[i][7:0]);
            n_checks++;
            if ({o_rx_ready, o_set_mode, o_mode, o_set_color, o_color, o_err, o_err_code, o_err_count} !==
                {exp_ready, exp_set_mode, exp_mode, exp_set_color, exp_color, exp_err, exp_code, exp_count}) begin
                n_fail++;
                $display("FAIL random[%0d] got rdy%b m%b/%h c%b/%h e%b/%0d/%0d want rdy%b m%b/%h c%b/%h e%b/%0d/%0d", i,
                         o_rx_ready, o_set_mode, o_mode, o_set_color, o_color, o_err, o_err_code, o_err_count,
                         exp_ready, exp_set_mode, exp_mode, exp_set_color, exp_color, exp_err, exp_code, exp_count);
            end
        end
        step(1'b0, 8'h00);
    endtask

    task automatic test_reset_and_saturate();
        int expect_cnt;
        step(1'b1, 8'hA5); step(1'b1, 8'h01); step(1'b1, 8'h00);
        #2 i_reset = 1'b1;
        #1;
        n_checks++; if ({o_rx_ready, o_set_mode, o_set_color, o_err} !== 4'b1000) begin n_fail++; $display("FAIL async_reset_strobes got %b want 1000", {o_rx_ready, o_set_mode, o_set_color, o_err}); end
        n_checks++; if ({o_mode, o_color, o_err_code, o_err_count} !== 30'h0) begin n_fail++; $display("FAIL async_reset_values got %h/%h/%h/%h want 0", o_mode, o_color, o_err_code, o_err_count); end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_reset();
        send_pkt(8'h01, 8'h00, 8'h07, 8'h06);
        n_checks++; if (o_set_mode !== 1'b1 || o_mode !== 8'h07 || o_err !== 1'b0) begin n_fail++; $display("FAIL post_reset_pkt got %b/%h/%b want 1/07/0", o_set_mode, o_mode, o_err); end
        step(1'b0, 8'h00);
        expect_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            send_pkt(8'h01, 8'h00, 8'h00, 8'hFF);
            if (expect_cnt < 255) expect_cnt++;
            n_checks++; if (o_err !== 1'b1 || o_err_count !== 8'(expect_cnt)) begin n_fail++; $display("FAIL saturate[%0d] got %b/%0d want 1/%0d", k, o_err, o_err_count, expect_cnt); end
            step(1'b0, 8'h00);
        end
        n_checks++; if (o_err_count !== 8'hFF || o_err_code !== 2'd1) begin n_fail++; $display("FAIL saturate_final got %0d/%0d want 255/1", o_err_count, o_err_code); end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        model_reset();
        test_reset();
        test_set_mode();
        test_set_color();
        test_chk_error();
        test_bad_opcode();
        test_timeout();
        test_random();
        test_reset_and_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
